// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: start/busy/done sequencer for a shared single-round AES-128 datapath.
//
// Accepts one encrypt or decrypt request at a time and steps the external
// combinational round unit and key-step unit one round per cycle. The expanded
// key schedule is kept in an 11-entry register file so that decrypt can walk
// the round keys in reverse order. The result is returned on a valid/ready port.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready high only when idle)
//   in_decrypt            0 = encrypt, 1 = decrypt
//   in_data, in_key       128-bit block and cipher key, sampled on accept
//   out_valid/out_ready   result handshake, out_data held until accepted
//   busy                  high whenever not idle
//   rnd_in/rnd_key        state and round key to the round unit
//   rnd_last/rnd_dec      final-round (no (Inv)MixColumns) and inverse-round selects
//   rnd_out               round unit result (combinational)
//   ks_in/ks_round        previous round key and round index (1..10) to the key-step unit
//   ks_out                next round key (combinational)
//
// Build option: define AES_KEY_CACHE_EN to keep a schedule-valid flag so that a
// decrypt with the most recently expanded key skips the EXPAND pass.
module aes_round_ctrl #(
  parameter int unsigned NR = 10  // only 10 (AES-128) is supported
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [127:0] rnd_in,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  output logic         rnd_dec,
  input  logic [127:0] rnd_out,
  output logic [127:0] ks_in,
  output logic [3:0]   ks_round,
  input  logic [127:0] ks_out
);

  localparam logic [3:0] LastRnd = 4'(NR);

  typedef enum logic [2:0] {
    StIdle,
    StExpand,
    StEround,
    StDround,
    StOut
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] cur_key_q, cur_key_d;
  logic [3:0]   rnd_q, rnd_d;

  // Key schedule storage; entry i holds round key i.
  logic [127:0] kr_q [0:NR];
  logic         kr_we;
  logic [3:0]   kr_addr;
  logic [127:0] kr_wdata;
  logic [127:0] kr_rd;

  assign kr_rd = kr_q[rnd_q];

`ifdef AES_KEY_CACHE_EN
  logic sched_vld_q, sched_vld_d;
  logic key_match;
  logic cache_hit;

  assign key_match = (in_key == kr_q[0]);
  assign cache_hit = sched_vld_q && key_match;
`endif

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    cur_key_d = cur_key_q;
    rnd_d     = rnd_q;
    kr_we     = 1'b0;
    kr_addr   = rnd_q;
    kr_wdata  = ks_out;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_data  = '0;
    // Datapath outputs parked at zero outside the round states to limit toggling.
    rnd_in    = '0;
    rnd_key   = '0;
    rnd_last  = 1'b0;
    rnd_dec   = 1'b0;
    ks_in     = '0;
    ks_round  = '0;
`ifdef AES_KEY_CACHE_EN
    sched_vld_d = sched_vld_q;
`endif

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          kr_we     = 1'b1;
          kr_addr   = 4'd0;
          kr_wdata  = in_key;
          cur_key_d = in_key;
          rnd_d     = 4'd1;
`ifdef AES_KEY_CACHE_EN
          if (!key_match) begin
            sched_vld_d = 1'b0;
          end
`endif
          if (!in_decrypt) begin
            st_d    = in_data ^ in_key;
            state_d = StEround;
          end else begin
`ifdef AES_KEY_CACHE_EN
            if (cache_hit) begin
              // Schedule already holds this key: start straight at the last round key.
              st_d    = in_data ^ kr_q[NR];
              rnd_d   = LastRnd - 4'd1;
              state_d = StDround;
            end else begin
              st_d    = in_data;
              state_d = StExpand;
            end
`else
            st_d    = in_data;
            state_d = StExpand;
`endif
          end
        end
      end

      StEround: begin
        ks_in     = cur_key_q;
        ks_round  = rnd_q;
        rnd_in    = st_q;
        rnd_key   = ks_out;
        rnd_last  = (rnd_q == LastRnd);
        st_d      = rnd_out;
        cur_key_d = ks_out;
        kr_we     = 1'b1;
        if (rnd_q == LastRnd) begin
          // Counter is held at its maximum rather than wrapping past it.
          state_d = StOut;
`ifdef AES_KEY_CACHE_EN
          sched_vld_d = 1'b1;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      StExpand: begin
        ks_in     = cur_key_q;
        ks_round  = rnd_q;
        cur_key_d = ks_out;
        kr_we     = 1'b1;
        if (rnd_q == LastRnd) begin
          // Initial AddRoundKey of the inverse cipher uses the last round key.
          st_d    = st_q ^ ks_out;
          rnd_d   = LastRnd - 4'd1;
          state_d = StDround;
`ifdef AES_KEY_CACHE_EN
          sched_vld_d = 1'b1;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      StDround: begin
        rnd_in   = st_q;
        rnd_key  = kr_rd;
        rnd_dec  = 1'b1;
        rnd_last = (rnd_q == 4'd0);
        st_d     = rnd_out;
        if (rnd_q == 4'd0) begin
          state_d = StOut;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end

      StOut: begin
        out_valid = 1'b1;
        out_data  = st_q;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      st_q      <= '0;
      cur_key_q <= '0;
      rnd_q     <= '0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      cur_key_q <= cur_key_d;
      rnd_q     <= rnd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (kr_we && !reset) begin
      kr_q[kr_addr] <= kr_wdata;
    end
  end

`ifdef AES_KEY_CACHE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      sched_vld_q <= 1'b0;
    end else begin
      sched_vld_q <= sched_vld_d;
    end
  end
`endif

  // Round counter stays within the schedule and never under/overflows.
  a_rnd_range: assert property (@(posedge clock) disable iff (reset) rnd_q <= LastRnd);
  a_dround_rnd: assert property (@(posedge clock) disable iff (reset)
      (state_q == StDround) |-> (rnd_q < LastRnd));
  a_fwd_rnd: assert property (@(posedge clock) disable iff (reset)
      ((state_q == StEround) || (state_q == StExpand)) |-> (rnd_q != 4'd0));

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [127:0] rnd_in;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic         rnd_dec;
  logic [127:0] rnd_out;
  logic [127:0] ks_in;
  logic [3:0]   ks_round;
  logic [127:0] ks_out;

  aes_round_ctrl #(.NR(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_decrypt(in_decrypt),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .rnd_in    (rnd_in),
    .rnd_key   (rnd_key),
    .rnd_last  (rnd_last),
    .rnd_dec   (rnd_dec),
    .rnd_out   (rnd_out),
    .ks_in     (ks_in),
    .ks_round  (ks_round),
    .ks_out    (ks_out)
  );

  always #5 clock = ~clock;

`ifdef AES_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  localparam logic [127:0] KatKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KatPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KatCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];

  // Expected key-cache state, used only to predict decrypt latency.
  bit           cache_vld = 1'b0;
  logic [127:0] cache_key = '0;
  logic [127:0] last_key  = '0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];
  int         tbl_gen = 0;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[4*c+rr] = a[4*((c+rr)%4)+rr];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[4*c+rr] = isbox[a[4*((c+4-rr)%4)+rr]] ^ k[127-8*(4*c+rr) -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        b[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        b[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        b[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rn);
    logic [31:0] t, w0, w1, w2, w3;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < int'(rn); i++) rc = xt(rc);
    t  = {k[23:0], k[31:24]};
    t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [127:0] k;
    k = key;
    for (int r = 1; r <= n; r++) k = key_step(k, 4'(r));
    return k;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 1; r <= 10; r++) begin
      k = key_step(k, 4'(r));
      s = enc_round(s, k, r == 10);
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s;
    s = ct ^ round_key(key, 10);
    for (int r = 9; r >= 0; r--) s = dec_round(s, round_key(key, r), r == 0);
    return s;
  endfunction

  // External round and key-step units.
  always @(rnd_in, rnd_key, rnd_last, rnd_dec, tbl_gen)
    rnd_out = rnd_dec ? dec_round(rnd_in, rnd_key, rnd_last)
                      : enc_round(rnd_in, rnd_key, rnd_last);
  always @(ks_in, ks_round, tbl_gen)
    ks_out = key_step(ks_in, ks_round);

  // ---------------- bench tasks ----------------
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    cache_vld = 1'b0;
    exp_q.delete();
  endtask

  // Presents one request, returns at the negedge of cycle 1 with the predicted latency.
  task automatic send(input logic dec, input logic [127:0] data, input logic [127:0] key,
                      input logic [127:0] exp, output int lat_exp);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid   = 1'b1;
    in_decrypt = dec;
    in_data    = data;
    in_key     = key;
    lat_exp = (dec && !(CacheEn && cache_vld && key == cache_key)) ? 21 : 11;
    if (key != cache_key) cache_vld = 1'b0;
    last_key = key;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat_exp, input int hold, input bit scramble,
                             input string name);
    int lat;
    bit busy_ok;
    logic [127:0] held, exp;
    lat     = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (scramble) begin
        in_data    = rand128();
        in_key     = rand128();
        in_decrypt = 1'($urandom);
      end
      tick();
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    n_vec++;
    if (lat != lat_exp) begin
      n_err++;
      $display("FAIL %s_latency: out_valid at cycle %0d required %0d", name, lat, lat_exp);
    end
    n_vec++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL %s_busy: busy dropped before result, required 1 on cycles 1..%0d",
               name, lat_exp);
    end
    if (out_valid === 1'b1) begin
      cache_vld = 1'b1;
      cache_key = last_key;
    end
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      // A competing request during OUT must be held off.
      in_valid   = 1'b1;
      in_decrypt = 1'b0;
      in_data    = ~held;
      tick();
      n_vec++;
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s_hold: out_data=%h out_valid=%b in_ready=%b required %h 1 0",
                 name, out_data, out_valid, in_ready, held);
      end
    end
    out_ready = 1'b1;
    exp = '0;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_queue: result with no expected value, got %h", name, out_data);
    end else begin
      exp = exp_q.pop_front();
      n_vec++;
      if (out_data !== exp) begin
        n_err++;
        $display("FAIL %s_data: out_data=%h required %h", name, out_data, exp);
      end
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b out_data=%h required 1 0 0 0",
               in_ready, busy, out_valid, out_data);
    end
    n_vec++;
    if (rnd_last !== 1'b0 || rnd_dec !== 1'b0 || rnd_in !== '0 || ks_round !== 4'd0) begin
      n_err++;
      $display("FAIL reset_dp: rnd_last=%b rnd_dec=%b rnd_in=%h ks_round=%0d required 0 0 0 0",
               rnd_last, rnd_dec, rnd_in, ks_round);
    end
  endtask

  task automatic test_encrypt_kat();
    int lat;
    do_reset();
    send(1'b0, KatPt, KatKey, KatCt, lat);
    n_vec++;
    if (rnd_in !== (KatPt ^ KatKey) || ks_round !== 4'd1 || rnd_dec !== 1'b0) begin
      n_err++;
      $display("FAIL enc_first_round: rnd_in=%h ks_round=%0d rnd_dec=%b required %h 1 0",
               rnd_in, ks_round, rnd_dec, KatPt ^ KatKey);
    end
    wait_result(lat, 0, 1'b0, "enc_kat");
  endtask

  task automatic test_decrypt_kat();
    int lat;
    do_reset();
    send(1'b1, KatCt, KatKey, KatPt, lat);
    wait_result(lat, 0, 1'b0, "dec_kat");
  endtask

  task automatic test_enc_then_dec();
    int lat;
    logic [127:0] pt, ct;
    pt = rand128();
    ct = ref_enc(pt, KatKey);
    send(1'b0, pt, KatKey, ct, lat);
    wait_result(lat, 0, 1'b0, "pair_enc");
    send(1'b1, ct, KatKey, pt, lat);
    wait_result(lat, 0, 1'b0, "pair_dec");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] k, p;
    k = rand128();
    p = rand128();
    send(1'b0, p, k, ref_enc(p, k), lat);
    wait_result(lat, 5, 1'b0, "hold_enc");
    p = rand128();
    send(1'b0, p, k, ref_enc(p, k), lat);
    wait_result(lat, 0, 1'b0, "b2b_enc");
  endtask

  task automatic test_reset_abort();
    int lat;
    do_reset();
    send(1'b1, KatCt, KatKey, KatPt, lat);
    repeat (15) tick();
    n_vec++;
    if (rnd_dec !== 1'b1 || rnd_key !== round_key(KatKey, 4)) begin
      n_err++;
      $display("FAIL abort_rnd4: rnd_dec=%b rnd_key=%h required 1 %h",
               rnd_dec, rnd_key, round_key(KatKey, 4));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cache_vld = 1'b0;
    exp_q.delete();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || rnd_dec !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: out_valid=%b in_ready=%b busy=%b rnd_dec=%b required 0 1 0 0",
               out_valid, in_ready, busy, rnd_dec);
    end
    send(1'b1, KatCt, KatKey, KatPt, lat);
    wait_result(lat, 0, 1'b0, "abort_redo");
  endtask

  task automatic test_operand_change();
    int lat;
    logic [127:0] k, p, c;
    k = rand128();
    p = rand128();
    c = ref_enc(p, k);
    send(1'b0, p, k, c, lat);
    wait_result(lat, 0, 1'b1, "chg_enc");
    k = rand128();
    send(1'b1, c, k, ref_dec(c, k), lat);
    wait_result(lat, 0, 1'b1, "chg_dec");
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] k, d;
    logic dec;
    k = rand128();
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) k = rand128();
      d   = rand128();
      dec = 1'(i % 2);
      send(dec, d, k, dec ? ref_dec(d, k) : ref_enc(d, k), lat);
      wait_result(lat, i % 3, 1'b0, "rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    tbl_gen    = 1;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_decrypt = 1'b0;
    in_data    = '0;
    in_key     = '0;
    out_ready  = 1'b0;
    @(negedge clock);

    test_reset();
    test_encrypt_kat();
    test_decrypt_kat();
    test_enc_then_dec();
    test_back_to_back();
    test_reset_abort();
    test_operand_change();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the shared single-round AES-128 datapath. It accepts one block request at a time, which is either an encrypt or a decrypt. It drives the external combinational round unit and key-step unit one round per cycle and stores the expanded key schedule. It returns the result through a valid/ready handshake. It sits between the host request interface and the round/key-step logic, replacing free-running round counters with an explicit start/busy/done controller.

## Interface
Parameters:
- NR, 10, number of AES rounds; the only supported value is 10.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request; high only in IDLE.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  128  plaintext or ciphertext.
- in_key  in  128  cipher key.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result block.
- busy  out  1  high in any state other than IDLE.
- rnd_in  out  128  state presented to the round unit.
- rnd_key  out  128  round key presented to the round unit.
- rnd_last  out  1  final round, which omits (Inv)MixColumns.
- rnd_dec  out  1  inverse round select.
- rnd_out  in  128  round unit result (combinational).
- ks_in  out  128  previous round key.
- ks_round  out  4  round index 1..10, used for rcon.
- ks_out  in  128  next round key (combinational).

## Operation
- Storage:
  - st: 128-bit state register.
  - cur_key: 128-bit register.
  - kr[0:10]: key schedule RAM, 11 x 128 bits.
  - rnd: 4-bit counter.
- States: IDLE, EXPAND, EROUND, DROUND, OUT.
- IDLE, accept when in_valid && in_ready:
  - Always: kr[0] <= in_key, cur_key <= in_key, rnd <= 1.
  - Encrypt: st <= in_data ^ in_key, go to EROUND.
  - Decrypt: st <= in_data, go to EXPAND.
- EROUND:
  - Drives ks_in=cur_key, ks_round=rnd, rnd_in=st, rnd_key=ks_out, rnd_dec=0, rnd_last=(rnd==10).
  - Updates st <= rnd_out, cur_key <= ks_out, kr[rnd] <= ks_out, rnd <= rnd+1.
  - When rnd==10, go to OUT.
- EXPAND:
  - Drives ks_in=cur_key, ks_round=rnd.
  - Updates kr[rnd] <= ks_out, cur_key <= ks_out, rnd <= rnd+1.
  - When rnd==10: st <= st ^ ks_out, rnd <= 9, go to DROUND.
- DROUND:
  - Drives rnd_in=st, rnd_key=kr[rnd], rnd_dec=1, rnd_last=(rnd==0).
  - Updates st <= rnd_out, rnd <= rnd-1.
  - When rnd==0, go to OUT.
- OUT:
  - out_valid=1, out_data=st.
  - On out_ready, go to IDLE. A new request is not accepted in the same cycle.
- Idle datapath outputs: rnd_*/ks_* outputs are don't-care outside EROUND/EXPAND/DROUND. They are held at 0 to limit toggling.
- rnd never leaves 0..10. Decrement below 0 and increment above 10 cannot occur by construction; assertions cover this.
- in_data, in_key and in_decrypt are sampled only on the accept cycle. Later changes are ignored.

## Timing
- Reset values:
  - State=IDLE, in_ready=1, busy=0, out_valid=0, out_data=0.
  - st=0, rnd=0, rnd_last=0, rnd_dec=0.
  - Schedule-valid flag cleared.
- Reset asserted in any state aborts the operation. The next cycle is IDLE with the values above. A pending result is lost.
- Encrypt: accepted at cycle 0, EROUND on cycles 1..10, out_valid from cycle 11.
- Decrypt, schedule not cached: EXPAND on cycles 1..10, DROUND on cycles 11..20, out_valid from cycle 21.
- out_valid and out_data stay stable until out_ready is sampled high. in_ready rises the cycle after the handshake.
- in_valid while busy: the request is held off (in_ready=0) and the bench must keep it stable.

## Configuration
- AES_KEY_CACHE_EN defined:
  - A schedule-valid flag is set at the end of EROUND rnd==10 or EXPAND rnd==10, and cleared by reset.
  - On a decrypt accept with the flag set and in_key==kr[0], EXPAND is skipped: st <= in_data ^ kr[10], rnd <= 9, go directly to DROUND. out_valid is then at cycle 11.
  - An accept with a different key clears the flag on the accept cycle.
- AES_KEY_CACHE_EN undefined: no flag and no comparator; every decrypt runs EXPAND.

## Test plan
- Reset, then an encrypt of key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid first at cycle 11, busy high on cycles 1..11.
- Reset, then a decrypt of ct 69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> out_data 00112233445566778899aabbccddeeff at cycle 21.
- Encrypt, then decrypt with the same key -> with AES_KEY_CACHE_EN the decrypt result appears at cycle 11 after accept; without the macro it appears at cycle 21. The data is correct in both builds.
- Hold out_ready=0 for 5 cycles in OUT -> out_data is stable, in_ready=0, no new accept; accept again 1 cycle after out_ready.
- Assert reset during DROUND at rnd==4 -> next cycle IDLE, out_valid=0. A following decrypt with the same key runs the full EXPAND, because the cache was invalidated.
- Change in_data/in_key while busy -> result equals the value computed from the operands sampled at accept.
